// File: rtl/eh2_lsu_amo_seq_if.sv
// Bus bundle between the LSU atomic sequencer and its requesters, DCCM port,
// store snoop, AMO ALU and response sink.
interface eh2_lsu_amo_seq_if #(
  parameter int unsigned NUM_THREADS = 2
);
  logic [NUM_THREADS-1:0]        req_valid;
  logic [NUM_THREADS-1:0]        req_ready;
  logic [NUM_THREADS-1:0][4:0]   req_op;
  logic [NUM_THREADS-1:0][31:0]  req_addr;
  logic [NUM_THREADS-1:0][31:0]  req_data;
  logic [NUM_THREADS-1:0]        flush;

  logic        mem_rd_valid;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_done;
  logic [31:0] mem_rd_data;
  logic        mem_rd_err;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_done;

  logic        snoop_wr_valid;
  logic [31:0] snoop_wr_addr;

  logic        amo_valid;
  logic [4:0]  amo_op;
  logic [31:0] amo_operand1;
  logic [31:0] amo_operand2;
  logic [31:0] amo_result;

  logic        rsp_valid;
  logic        rsp_tid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    input  req_valid, req_op, req_addr, req_data, flush,
    input  mem_rd_done, mem_rd_data, mem_rd_err, mem_wr_done,
    input  snoop_wr_valid, snoop_wr_addr, amo_result,
    output req_ready, mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
    output amo_valid, amo_op, amo_operand1, amo_operand2,
    output rsp_valid, rsp_tid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_data, flush,
    output mem_rd_done, mem_rd_data, mem_rd_err, mem_wr_done,
    output snoop_wr_valid, snoop_wr_addr, amo_result,
    input  req_ready, mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  amo_valid, amo_op, amo_operand1, amo_operand2,
    input  rsp_valid, rsp_tid, rsp_data, rsp_err
  );
endinterface

// File: rtl/eh2_lsu_amo_seq.sv
// Two-thread round-robin sequencer for AMO/LR/SC read-modify-write on the DCCM,
// including per-thread LR reservations and SC resolution.
module eh2_lsu_amo_seq #(
  parameter int unsigned NUM_THREADS = 2
) (
  input  logic               clk,
  input  logic               rst_l,
  eh2_lsu_amo_seq_if.master  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;
  localparam int unsigned WAW  = XLEN - 2;
  localparam logic [OPW-1:0] OP_LR = 5'd2;
  localparam logic [OPW-1:0] OP_SC = 5'd3;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

  state_t                         state;
  logic                           idle_q;
  logic                           ptr;
  logic                           tid_q;
  logic [OPW-1:0]                 op_q;
  logic [XLEN-1:0]                addr_q;
  logic [XLEN-1:0]                data_q;
  logic [XLEN-1:0]                old_q;
  logic [NUM_THREADS-1:0]         rsv_vld;
  logic [NUM_THREADS-1:0][WAW-1:0] rsv_addr;
  logic [NUM_THREADS-1:0]         rsv_clr;
  logic [NUM_THREADS-1:0]         rsv_set;
  logic [NUM_THREADS-1:0]         gnt;
  logic                           gnt_tid;
  logic                           hs;
  logic                           sc_hit;
  logic [OPW-1:0]                 sel_op;
  logic [XLEN-1:0]                sel_addr;
  logic [XLEN-1:0]                sel_data;

  // Round-robin pick; idle_q keeps grants off during reset and busy states.
  always_comb begin
    gnt_tid  = (bus.req_valid[0] && bus.req_valid[1]) ? ptr : bus.req_valid[1];
    gnt      = '0;
    if (idle_q && (|bus.req_valid)) gnt[gnt_tid] = 1'b1;
    hs       = |gnt;
    sel_op   = bus.req_op[gnt_tid];
    sel_addr = bus.req_addr[gnt_tid];
    sel_data = bus.req_data[gnt_tid];
    sc_hit   = rsv_vld[gnt_tid] && (rsv_addr[gnt_tid] == sel_addr[XLEN-1:2]);
  end

  assign bus.req_ready = gnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state            <= IDLE;
      idle_q           <= 1'b0;
      ptr              <= 1'b0;
      tid_q            <= 1'b0;
      op_q             <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      old_q            <= '0;
      bus.mem_rd_valid <= 1'b0;
      bus.mem_rd_addr  <= '0;
      bus.mem_wr_valid <= 1'b0;
      bus.mem_wr_addr  <= '0;
      bus.mem_wr_data  <= '0;
      bus.amo_valid    <= 1'b0;
      bus.amo_op       <= '0;
      bus.amo_operand1 <= '0;
      bus.amo_operand2 <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_tid      <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_q <= ~hs;
          if (hs) begin
            ptr    <= ~gnt_tid;
            tid_q  <= gnt_tid;
            op_q   <= sel_op;
            addr_q <= sel_addr;
            data_q <= sel_data;
            if (sel_addr[1:0] != 2'b00) begin
              state           <= RESP;
              bus.rsp_valid   <= 1'b1;
              bus.rsp_tid     <= gnt_tid;
              bus.rsp_err     <= 1'b1;
              bus.rsp_data    <= '0;
            end else if (sel_op == OP_SC) begin
              if (sc_hit) begin
                state            <= WRITE;
                bus.mem_wr_valid <= 1'b1;
                bus.mem_wr_addr  <= sel_addr;
                bus.mem_wr_data  <= sel_data;
              end else begin
                state         <= RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_tid   <= gnt_tid;
                bus.rsp_data  <= XLEN'(1);
              end
            end else begin
              state            <= READ;
              bus.mem_rd_valid <= 1'b1;
              bus.mem_rd_addr  <= sel_addr;
            end
          end
        end
        READ: begin
          if (bus.mem_rd_done) begin
            bus.mem_rd_valid <= 1'b0;
            old_q            <= bus.mem_rd_data;
            if (bus.mem_rd_err) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_tid   <= tid_q;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else if (op_q == OP_LR) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_tid   <= tid_q;
              bus.rsp_data  <= bus.mem_rd_data;
            end else begin
              state            <= EXEC;
              bus.amo_valid    <= 1'b1;
              bus.amo_op       <= op_q;
              bus.amo_operand1 <= bus.mem_rd_data;
              bus.amo_operand2 <= data_q;
            end
          end
        end
        EXEC: begin
          state            <= WRITE;
          bus.amo_valid    <= 1'b0;
          bus.mem_wr_valid <= 1'b1;
          bus.mem_wr_addr  <= addr_q;
          bus.mem_wr_data  <= bus.amo_result;
        end
        WRITE: begin
          if (bus.mem_wr_done) begin
            state            <= RESP;
            bus.mem_wr_valid <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_tid      <= tid_q;
            bus.rsp_data     <= (op_q == OP_SC) ? '0 : old_q;
          end
        end
        RESP: begin
          state         <= IDLE;
          idle_q        <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_tid   <= 1'b0;
          bus.rsp_data  <= '0;
          bus.rsp_err   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  // A clear in the same cycle as an LR set leaves the reservation invalid.
  always_comb begin
    rsv_clr = '0;
    rsv_set = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      rsv_clr[t] = bus.flush[t]
                 | ((state == RESP) && (op_q == OP_SC) && (tid_q == 1'(t)))
                 | ((state == WRITE) && bus.mem_wr_done
                    && (bus.mem_wr_addr[XLEN-1:2] == rsv_addr[t]))
                 | (bus.snoop_wr_valid && (bus.snoop_wr_addr[XLEN-1:2] == rsv_addr[t]));
      rsv_set[t] = (state == READ) && bus.mem_rd_done && !bus.mem_rd_err
                 && (op_q == OP_LR) && (tid_q == 1'(t));
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsv_vld  <= '0;
      rsv_addr <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (rsv_clr[t]) begin
          rsv_vld[t] <= 1'b0;
        end else if (rsv_set[t]) begin
          rsv_vld[t]  <= 1'b1;
          rsv_addr[t] <= addr_q[XLEN-1:2];
        end
      end
    end
  end
endmodule

// File: doc/eh2_lsu_amo_seq.md
# eh2_lsu_amo_seq

Sequencer and two-thread arbiter for the LSU atomic (AMO/LR/SC) read-modify-write datapath. It accepts atomic requests from both hart threads and grants one at a time, round-robin. For each granted request it runs DCCM read, compute and write phases around the shared combinational AMO ALU, then returns the old memory value. It also holds one LR reservation per thread and resolves SC success or failure.

## Interface
Parameters:
- NUM_THREADS, 2, number of requesting threads (fixed at 2 for this revision)

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- req_valid  in  [1:0]  per-thread atomic request valid
- req_ready  out  [1:0]  per-thread grant; request accepted when valid & ready
- req_op  in  [1:0][4:0]  atomic_instr[4:0] encoding (0 add, 1 swap, 2 LR, 3 SC, 4 xor, 8 or, 12 and, 16 min, 20 max, 24 minu, 28 maxu)
- req_addr  in  [1:0][31:0]  word address
- req_data  in  [1:0][31:0]  store operand
- flush  in  [1:0]  per-thread flush; clears that thread's reservation
- mem_rd_valid  out  1  DCCM read request, held until mem_rd_done
- mem_rd_addr  out  32  read address
- mem_rd_done  in  1  read data valid this cycle
- mem_rd_data  in  32  ECC-corrected read data
- mem_rd_err  in  1  uncorrectable error on read
- mem_wr_valid  out  1  DCCM write request, held until mem_wr_done
- mem_wr_addr  out  32  write address
- mem_wr_data  out  32  write data
- mem_wr_done  in  1  write accepted
- snoop_wr_valid  in  1  a non-atomic store to DCCM committed this cycle
- snoop_wr_addr  in  32  its address
- amo_valid  out  1  AMO ALU operands valid (EXEC state)
- amo_op  out  5  op to AMO ALU
- amo_operand1  out  32  loaded memory value
- amo_operand2  out  32  store operand
- amo_result  in  32  ALU result (combinational, same cycle)
- rsp_valid  out  1  one-cycle completion pulse; always accepted
- rsp_tid  out  1  thread of completed request
- rsp_data  out  32  old value (AMO/LR), 0 = SC success, 1 = SC fail
- rsp_err  out  1  misaligned or read error

## Operation
- FSM states: IDLE, READ, EXEC, WRITE, RESP. Reset state is IDLE.
- IDLE: the arbiter selects one requesting thread and asserts its req_ready. On handshake, op, addr, data and tid are latched.
  - Misaligned address (addr[1:0] != 0) -> RESP with rsp_err=1. No memory access.
  - SC with matching valid reservation (own thread, addr[31:2] equal) -> WRITE with data = req_data.
  - SC without a matching reservation -> RESP with rsp_data=1.
  - All other ops -> READ.
- READ: mem_rd_valid held until mem_rd_done. The latched old value is captured.
  - mem_rd_err -> RESP with rsp_err=1. No write.
  - LR -> set own reservation to {1, addr[31:2]}, then RESP.
  - Other ops -> EXEC.
- EXEC: exactly one cycle. amo_valid=1; amo_result is latched as write data -> WRITE.
- WRITE: mem_wr_valid held until mem_wr_done -> RESP.
- RESP: rsp_valid=1 for one cycle -> IDLE.
  - rsp_data is the old value for AMO/LR, and 0 for a successful SC.
- Arbitration: round-robin pointer, reset to thread 0. After each grant the pointer moves to the other thread. A sole requester always wins.
- Reservation clears:
  - own SC, success or fail, at the RESP cycle;
  - flush[t];
  - a WRITE-state completion or snoop_wr_valid whose addr[31:2] matches any reservation, including the other thread's.
- If a clear and an LR set hit the same reservation in the same cycle, clear wins and the reservation stays invalid.
- req_ready is 0 in every state other than IDLE.

## Timing
- Reset values: all outputs 0, reservations invalid, pointer=0.
- Asynchronous reset mid-operation aborts to IDLE. Any pending memory request drops immediately and no response is produced.
- AMO minimum latency, with read and write done on the first cycle:
  - accept cycle N, READ N+1, EXEC N+2, WRITE N+3, rsp_valid N+4.
- LR minimum latency: rsp_valid at N+2.
- SC success minimum latency: rsp_valid at N+2. SC fail and misaligned: rsp_valid at N+1.
- Earliest next grant is the cycle after RESP, with a one-cycle IDLE between requests.
- Memory stalls extend READ or WRITE indefinitely. Address and data outputs stay stable while valid is high.

## Test plan
- Both threads request amoadd at 0x100 in the same cycle, memory=5, data 3 and 4:
  - thread 0 is granted first and gets rsp_data=5, then thread 1 gets rsp_data=8;
  - final memory is 12.
- Thread 0 LR 0x200 then SC 0x200 with data 0xAA -> SC rsp_data=0 and memory 0xAA. A second SC -> rsp_data=1 and no mem_wr_valid.
- Thread 0 LR 0x200, then a snoop write to 0x202 -> the reservation clears and the SC returns 1. The same test with the snoop at 0x204 -> the SC returns 0.
- amomaxu at 0x300: memory 0xFFFFFFFF, data 1 -> write 0xFFFFFFFF. amomax with the same values -> write 1. Both respond with 0xFFFFFFFF.
- amoswap at 0x103 -> rsp_err=1 at N+1 with no memory traffic. An LR with mem_rd_err -> rsp_err=1 and the reservation is not set.
- mem_wr_done delayed 3 cycles -> mem_wr_valid and mem_wr_addr stay stable. Reset asserted during the delay -> all outputs 0 and no rsp_valid.
